// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_pkg
// Description : Shared encodings for the register-bank sequencer. Holds the
//               register-bank command codes, the decoder op codes and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  // Register-bank command codes
  localparam logic [2:0] CTRL_DEFAULT = 3'd0;
  localparam logic [2:0] CTRL_ALU     = 3'd1;
  localparam logic [2:0] CTRL_LOAD    = 3'd3;
  localparam logic [2:0] CTRL_TRAP    = 3'd4;
  localparam logic [2:0] CTRL_RETURN  = 3'd5;
  localparam logic [2:0] CTRL_CPXR    = 3'd6;

  // Decoder op codes (4 and 7 are illegal)
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_SWI    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_RETURN = 3'd5;
  localparam logic [2:0] OP_CPXR   = 3'd6;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/regbank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : regbank_sequencer_if
// Description : Decoder/memory-side request signals and register-bank command
//               signals of the sequencer.
//   master : drives instr_valid/op/rd, branch_taken, mem_ready, irq;
//            observes instr_ready and the command outputs.
//   slave  : the sequencer itself (mirror of master).
// Revision    : 1.0 - initial release
// ============================================================================
interface regbank_sequencer_if;
  import regbank_pkg::*;

  logic       instr_valid;
  logic [2:0] instr_op;
  logic [3:0] instr_rd;
  logic       branch_taken;
  logic       mem_ready;
  logic       irq;
  logic       instr_ready;
  logic       bank_enable;
  logic [2:0] bank_control;
  logic [3:0] bank_dest;
  logic       should_branch;
  logic       privileged;
  logic       mem_fault;

  modport master (
    output instr_valid, instr_op, instr_rd, branch_taken, mem_ready, irq,
    input  instr_ready, bank_enable, bank_control, bank_dest, should_branch,
           privileged, mem_fault
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, branch_taken, mem_ready, irq,
    output instr_ready, bank_enable, bank_control, bank_dest, should_branch,
           privileged, mem_fault
  );

endinterface
`default_nettype wire

// File: rtl/regbank_load_timer.sv
`default_nettype none
// ============================================================================
// Module      : regbank_load_timer
// Description : Load-wait cycle counter with synchronous clear and count
//               enable; terminal_o flags the final allowed wait cycle.
//   slow_clock : clock, rising edge
//   reset      : asynchronous active-low reset
//   clear_i    : force count to zero (has priority over enable_i)
//   enable_i   : increment count
//   terminal_o : count == MEM_TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_load_timer
  import regbank_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  wire logic slow_clock,
  input  wire logic reset,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      terminal_o
);

  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regbank_sequencer
// Description : Turns decoded instructions, load completions and interrupts
//               into at most one registered register-bank command per cycle
//               and owns the privileged-mode flag.
//   slow_clock : clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : request inputs / command outputs (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_sequencer
  import regbank_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  wire logic          slow_clock,
  input  wire logic          reset,
  regbank_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] rd_q, rd_d;
  logic       pend_q, pend_d;
  logic       priv_q, priv_d;
  logic       en_q, en_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [3:0] dest_q, dest_d;
  logic       br_q, br_d;
  logic       fault_q, fault_d;
  logic       w_terminal;
  logic       w_irq_trap;

  // Counter sits at zero outside LOAD_WAIT, so each load starts a fresh window.
  regbank_load_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_timer (
    .slow_clock (slow_clock),
    .reset      (reset),
    .clear_i    (state_q != LOAD_WAIT),
    .enable_i   ((state_q == LOAD_WAIT) && !bus.mem_ready),
    .terminal_o (w_terminal)
  );

  // A pending interrupt is only serviceable from user mode.
  assign w_irq_trap = pend_q && !priv_q;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    // irq sets pending on every cycle it is high, even the cycle the trap fires.
    pend_d  = pend_q | bus.irq;
    priv_d  = priv_q;
    en_d    = 1'b0;
    ctrl_d  = CTRL_DEFAULT;
    dest_d  = '0;
    br_d    = 1'b0;
    fault_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_irq_trap) begin
          en_d   = 1'b1;
          ctrl_d = CTRL_TRAP;
          priv_d = 1'b1;
          pend_d = bus.irq;
        end else if (bus.instr_valid) begin
          case (bus.instr_op)
            OP_ALU: begin
              en_d   = 1'b1;
              ctrl_d = CTRL_ALU;
              dest_d = bus.instr_rd;
              br_d   = bus.branch_taken;
            end
            OP_NOP: begin
              en_d   = 1'b1;
              ctrl_d = CTRL_DEFAULT;
            end
            OP_LOAD: begin
              rd_d    = bus.instr_rd;
              state_d = LOAD_WAIT;
            end
            OP_RETURN: begin
              en_d = 1'b1;
              if (priv_q) begin
                ctrl_d = CTRL_RETURN;
                priv_d = 1'b0;
              end else begin
                ctrl_d = CTRL_TRAP;
                priv_d = 1'b1;
              end
            end
            OP_CPXR: begin
              en_d = 1'b1;
              if (priv_q) begin
                ctrl_d = CTRL_CPXR;
                dest_d = bus.instr_rd;
              end else begin
                ctrl_d = CTRL_TRAP;
                priv_d = 1'b1;
              end
            end
            // SWI and illegal ops both enter the trap handler.
            default: begin
              en_d   = 1'b1;
              ctrl_d = CTRL_TRAP;
              priv_d = 1'b1;
            end
          endcase
        end
      end

      LOAD_WAIT: begin
        // Data arriving on the timeout cycle still wins over the fault.
        if (bus.mem_ready) begin
          en_d    = 1'b1;
          ctrl_d  = CTRL_LOAD;
          dest_d  = rd_q;
          state_d = IDLE;
        end else if (w_terminal) begin
          en_d    = 1'b1;
          ctrl_d  = CTRL_TRAP;
          priv_d  = 1'b1;
          fault_d = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      pend_q  <= 1'b0;
      priv_q  <= 1'b0;
      en_q    <= 1'b0;
      ctrl_q  <= CTRL_DEFAULT;
      dest_q  <= '0;
      br_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      priv_q  <= priv_d;
      en_q    <= en_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      br_q    <= br_d;
      fault_q <= fault_d;
    end
  end

  assign bus.instr_ready   = (state_q == IDLE) && !w_irq_trap;
  assign bus.bank_enable   = en_q;
  assign bus.bank_control  = ctrl_q;
  assign bus.bank_dest     = dest_q;
  assign bus.should_branch = br_q;
  assign bus.privileged    = priv_q;
  assign bus.mem_fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_sequencer
// Description : Directed self-checking bench for regbank_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_sequencer;

  logic slow_clock = 1'b0;
  logic reset      = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  regbank_sequencer_if bus();

  regbank_sequencer #(
    .MEM_TIMEOUT (16),
    .CNT_WIDTH   (5)
  ) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic en, input logic [2:0] ctrl,
                           input logic [3:0] dest, input logic br);
    check({tag, ".enable"},  {7'd0, bus.bank_enable},   {7'd0, en});
    check({tag, ".control"}, {5'd0, bus.bank_control},  {5'd0, ctrl});
    check({tag, ".dest"},    {4'd0, bus.bank_dest},     {4'd0, dest});
    check({tag, ".branch"},  {7'd0, bus.should_branch}, {7'd0, br});
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic br);
    bus.instr_valid  = 1'b1;
    bus.instr_op     = op;
    bus.instr_rd     = rd;
    bus.branch_taken = br;
    tick();
    bus.instr_valid  = 1'b0;
    bus.instr_op     = 3'd0;
    bus.instr_rd     = 4'd0;
    bus.branch_taken = 1'b0;
  endtask

  initial begin
    bus.instr_valid  = 1'b0;
    bus.instr_op     = 3'd0;
    bus.instr_rd     = 4'd0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.irq          = 1'b0;

    // Reset state
    tick();
    tick();
    check_cmd("reset", 1'b0, 3'd0, 4'd0, 1'b0);
    check("reset.priv",  {7'd0, bus.privileged}, 8'd0);
    check("reset.fault", {7'd0, bus.mem_fault},  8'd0);
    check("reset.ready", {7'd0, bus.instr_ready}, 8'd1);
    reset = 1'b1;
    tick();

    // ALU rd=3 with branch
    issue(3'd1, 4'd3, 1'b1);
    check_cmd("alu", 1'b1, 3'd1, 4'd3, 1'b1);
    tick();
    check_cmd("alu.after", 1'b0, 3'd0, 4'd0, 1'b0);

    // ALU rd=12 without branch
    issue(3'd1, 4'd12, 1'b0);
    check_cmd("alu2", 1'b1, 3'd1, 4'd12, 1'b0);

    // NOP
    issue(3'd0, 4'd5, 1'b0);
    check_cmd("nop", 1'b1, 3'd0, 4'd0, 1'b0);

    // LOAD rd=7, data on the 4th wait cycle
    issue(3'd3, 4'd7, 1'b0);
    check("load7.ready0", {7'd0, bus.instr_ready}, 8'd0);
    check("load7.en0",    {7'd0, bus.bank_enable}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("load7.ready_wait", {7'd0, bus.instr_ready}, 8'd0);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check_cmd("load7", 1'b1, 3'd3, 4'd7, 1'b0);
    check("load7.fault", {7'd0, bus.mem_fault},  8'd0);
    check("load7.ready", {7'd0, bus.instr_ready}, 8'd1);

    // LOAD rd=2, never ready: fault on the 16th wait edge
    issue(3'd3, 4'd2, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("load2.nofault_yet", {7'd0, bus.mem_fault}, 8'd0);
    end
    tick();
    check("load2.fault", {7'd0, bus.mem_fault},  8'd1);
    check_cmd("load2.trap", 1'b1, 3'd4, 4'd0, 1'b0);
    check("load2.priv",  {7'd0, bus.privileged}, 8'd1);
    tick();
    check("load2.fault_pulse", {7'd0, bus.mem_fault},   8'd0);
    check("load2.en_pulse",    {7'd0, bus.bank_enable}, 8'd0);
    issue(3'd5, 4'd0, 1'b0);
    check_cmd("ret1", 1'b1, 3'd5, 4'd0, 1'b0);
    check("ret1.priv", {7'd0, bus.privileged}, 8'd0);

    // LOAD rd=8 with data exactly on the timeout cycle: completes, no fault
    issue(3'd3, 4'd8, 1'b0);
    for (int i = 1; i < 16; i++) tick();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check_cmd("edge_load", 1'b1, 3'd3, 4'd8, 1'b0);
    check("edge_load.fault", {7'd0, bus.mem_fault},  8'd0);
    check("edge_load.priv",  {7'd0, bus.privileged}, 8'd0);

    // irq pulse during LOAD_WAIT: load first, then trap
    issue(3'd3, 4'd4, 1'b0);
    bus.irq = 1'b1;
    tick();
    bus.irq = 1'b0;
    check("irqload.ready", {7'd0, bus.instr_ready}, 8'd0);
    check("irqload.en",    {7'd0, bus.bank_enable}, 8'd0);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check_cmd("irqload.load", 1'b1, 3'd3, 4'd4, 1'b0);
    check("irqload.ready_blocked", {7'd0, bus.instr_ready}, 8'd0);
    issue(3'd1, 4'd5, 1'b1);  // must not be accepted
    check_cmd("irqload.trap", 1'b1, 3'd4, 4'd0, 1'b0);
    check("irqload.priv",  {7'd0, bus.privileged},  8'd1);
    check("irqload.ready", {7'd0, bus.instr_ready}, 8'd1);
    issue(3'd5, 4'd0, 1'b0);
    check_cmd("ret2", 1'b1, 3'd5, 4'd0, 1'b0);

    // CPXR unprivileged traps; privileged CPXR and RETURN
    issue(3'd6, 4'd9, 1'b0);
    check_cmd("cpxr_user", 1'b1, 3'd4, 4'd0, 1'b0);
    check("cpxr_user.priv", {7'd0, bus.privileged}, 8'd1);
    issue(3'd6, 4'd9, 1'b0);
    check_cmd("cpxr_kern", 1'b1, 3'd6, 4'd9, 1'b0);
    issue(3'd5, 4'd0, 1'b0);
    check_cmd("ret3", 1'b1, 3'd5, 4'd0, 1'b0);
    check("ret3.priv", {7'd0, bus.privileged}, 8'd0);

    // Illegal op 4 and unprivileged RETURN trap
    issue(3'd4, 4'd1, 1'b0);
    check_cmd("illegal4", 1'b1, 3'd4, 4'd0, 1'b0);
    issue(3'd5, 4'd0, 1'b0);
    issue(3'd5, 4'd0, 1'b0);
    check_cmd("ret_user", 1'b1, 3'd4, 4'd0, 1'b0);
    check("ret_user.priv", {7'd0, bus.privileged}, 8'd1);
    issue(3'd5, 4'd0, 1'b0);
    check("ret4.priv", {7'd0, bus.privileged}, 8'd0);

    // SWI, then irq held while privileged, serviced after RETURN
    issue(3'd2, 4'd0, 1'b0);
    check_cmd("swi", 1'b1, 3'd4, 4'd0, 1'b0);
    check("swi.priv", {7'd0, bus.privileged}, 8'd1);
    bus.irq = 1'b1;
    tick();
    bus.irq = 1'b0;
    check("irqheld.ready", {7'd0, bus.instr_ready}, 8'd1);
    check("irqheld.en",    {7'd0, bus.bank_enable}, 8'd0);
    issue(3'd5, 4'd0, 1'b0);
    check_cmd("ret5", 1'b1, 3'd5, 4'd0, 1'b0);
    check("ret5.ready", {7'd0, bus.instr_ready}, 8'd0);
    tick();
    check_cmd("irqtrap", 1'b1, 3'd4, 4'd0, 1'b0);
    check("irqtrap.priv", {7'd0, bus.privileged}, 8'd1);
    issue(3'd5, 4'd0, 1'b0);

    // Reset asserted mid-LOAD_WAIT while privileged
    issue(3'd2, 4'd0, 1'b0);
    issue(3'd3, 4'd11, 1'b0);
    tick();
    check("prereset.priv", {7'd0, bus.privileged}, 8'd1);
    reset = 1'b0;
    #1;
    check("midreset.priv",  {7'd0, bus.privileged},  8'd0);
    check("midreset.ready", {7'd0, bus.instr_ready}, 8'd1);
    check_cmd("midreset", 1'b0, 3'd0, 4'd0, 1'b0);
    bus.mem_ready = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postreset.en",    {7'd0, bus.bank_enable},  8'd0);
      check("postreset.ctrl",  {5'd0, bus.bank_control}, 8'd0);
      check("postreset.ready", {7'd0, bus.instr_ready},  8'd1);
    end
    bus.mem_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
